wave_capture: RTL and testbench

Capture controller for the waveform sample RAM read by the scope display. Watches the decoded audio sample stream, waits for a positive-going zero crossing, writes 256 consecutive samples into the RAM half the display is not reading, then waits for display blanking and flips `read_index` so the display swaps to the new capture. It is the sole writer of the sample RAM and the sole driver of the display's buffer-select bit.

---
 rtl/wave_capture_pkg.sv | 13 +
 rtl/wave_capture_trigger.sv | 30 +++
 rtl/wave_capture.sv | 118 +++++++++++
 tb/tb_wave_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared state encodings and output-format constants for the waveform capture controller.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    STATE_ARMED  = 2'd0,
    STATE_ACTIVE = 2'd1,
    STATE_WAIT   = 2'd2
  } state_t;

  // Width of the offset-binary sample written to the display RAM.
  localparam int OB_W = 8;

endpackage

// File: rtl/wave_capture_trigger.sv
// Positive-going zero-crossing detector: remembers the sign of the last accepted
// sample and pulses crossing when a negative sample is followed by a non-negative one.
module wave_trigger
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  output logic                crossing
);

  logic prev_neg_r;

  // Sign of the most recent strobed sample, tracked in every controller state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_neg_r <= 1'b0;
    end else if (new_sample_ready) begin
      prev_neg_r <= new_sample_in[SAMPLE_W-1];
    end else begin
      prev_neg_r <= prev_neg_r;
    end
  end

  assign crossing = new_sample_ready & prev_neg_r & ~new_sample_in[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Capture controller: on a zero crossing writes 2^ADDR_LOG2 samples into the RAM half
// the display is not reading, then swaps halves on the next display-idle rising edge.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_sample_ready,
  input  logic [SAMPLE_W-1:0]  new_sample_in,
  input  logic                 wave_display_idle,
  output logic [ADDR_LOG2:0]   write_address,
  output logic                 write_enable,
  output logic [OB_W-1:0]      write_sample,
  output logic                 read_index
);

  localparam logic [ADDR_LOG2-1:0] COUNT_LAST = {ADDR_LOG2{1'b1}};

  state_t                 state_r, state_s;
  logic [ADDR_LOG2-1:0]   count_r, count_s;
  logic                   idle_prev_r;
  logic                   idle_rise_s;
  logic                   crossing_s;
  logic                   read_index_s;
  logic                   wr_en_s;
  logic [ADDR_LOG2:0]     wr_addr_s;
  logic [OB_W-1:0]        wr_data_s;
  logic [OB_W-1:0]        sample_ob_s;

  wave_trigger #(
    .SAMPLE_W(SAMPLE_W)
  ) u_trigger (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .crossing         (crossing_s)
  );

  assign idle_rise_s = wave_display_idle & ~idle_prev_r;
  assign sample_ob_s = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: OB_W-1]};

  // Next-state, capture counter and next values for the registered RAM/display outputs.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    read_index_s = read_index;
    wr_en_s      = 1'b0;
    wr_addr_s    = write_address;
    wr_data_s    = write_sample;
    case (state_r)
      STATE_ARMED: begin
        if (crossing_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {~read_index, {ADDR_LOG2{1'b0}}};
          wr_data_s = sample_ob_s;
          count_s   = ADDR_LOG2'(1);
          state_s   = STATE_ACTIVE;
        end else begin
          count_s   = {ADDR_LOG2{1'b0}};
        end
      end
      STATE_ACTIVE: begin
        if (new_sample_ready) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {~read_index, count_r};
          wr_data_s = sample_ob_s;
          count_s   = count_r + ADDR_LOG2'(1);
          if (count_r == COUNT_LAST) begin
            state_s = STATE_WAIT;
          end else begin
            state_s = STATE_ACTIVE;
          end
        end else begin
          state_s   = STATE_ACTIVE;
        end
      end
      STATE_WAIT: begin
        // A coincident strobe only feeds the trigger's sign history.
        if (idle_rise_s) begin
          read_index_s = ~read_index;
          state_s      = STATE_ARMED;
        end else begin
          state_s      = STATE_WAIT;
        end
      end
      default: begin
        state_s = STATE_ARMED;
        count_s = {ADDR_LOG2{1'b0}};
      end
    endcase
  end

  // State, counter, idle edge history and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= STATE_ARMED;
      count_r       <= {ADDR_LOG2{1'b0}};
      idle_prev_r   <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= {(ADDR_LOG2+1){1'b0}};
      write_sample  <= {OB_W{1'b0}};
    end else begin
      state_r       <= state_s;
      count_r       <= count_s;
      idle_prev_r   <= wave_display_idle;
      read_index    <= read_index_s;
      write_enable  <= wr_en_s;
      write_address <= wr_addr_s;
      write_sample  <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: expected RAM writes are queued as samples are driven
// and matched against the DUT's write strobes; buffer swaps and resets are checked directly.
module tb_wave_capture;
  import wave_capture_pkg::*;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int n_cmp;
  int n_err;
  logic [16:0] exp_q[$];

  wave_capture #(.SAMPLE_W(16), .ADDR_LOG2(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_ob(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  // Pop one expected write per observed strobe.
  always @(negedge clk) begin
    if (!reset && write_enable) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_write", {23'd0, write_address}, 32'h1ff_ffff);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check_value("wr_addr", 32'(write_address), 32'(e[16:8]));
        check_value("wr_data", 32'(write_sample), 32'(e[7:0]));
      end
    end
  end

  task automatic send(input logic [15:0] s, input bit exp_wr, input logic [8:0] exp_addr);
    @(posedge clk); #1;
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    if (exp_wr) exp_q.push_back({exp_addr, to_ob(s)});
    @(posedge clk); #1;
    new_sample_ready = 1'b0;
    check_value("wr_latency", 32'(write_enable), 32'(exp_wr));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    new_sample_ready = 1'b0;
    new_sample_in = 16'h0000;
    wave_display_idle = 1'b0;
    cycles(3);
    check_value("rst_we", 32'(write_enable), 32'd0);
    check_value("rst_addr", 32'(write_address), 32'd0);
    check_value("rst_data", 32'(write_sample), 32'd0);
    check_value("rst_ridx", 32'(read_index), 32'd0);
    check_value("rst_state", 32'(dut.state_r), 32'(STATE_ARMED));
    @(negedge clk) reset = 1'b0;

    // First capture into half 1, sequential single strobes.
    send(16'hFFFB, 1'b0, 9'h000);
    send(16'h0003, 1'b1, 9'h100);
    check_value("state_active1", 32'(dut.state_r), 32'(STATE_ACTIVE));
    for (int i = 1; i < 256; i++) begin
      logic [15:0] s;
      s = 16'(i * 200 - 20000);
      send(s, 1'b1, 9'h100 + 9'(i));
    end
    check_value("state_wait1", 32'(dut.state_r), 32'(STATE_WAIT));
    send(16'h1234, 1'b0, 9'h000);
    send(16'h0100, 1'b0, 9'h000);

    // Buffer swap on idle rising edge, level-high idle must not re-toggle.
    cycles(3);
    check_value("ridx_before_edge", 32'(read_index), 32'd0);
    wave_display_idle = 1'b1;
    @(posedge clk); #1;
    check_value("ridx_after_edge", 32'(read_index), 32'd1);
    check_value("state_armed_flip", 32'(dut.state_r), 32'(STATE_ARMED));
    cycles(100);
    check_value("ridx_level_high", 32'(read_index), 32'd1);

    // Idle pulse in ARMED is ignored; sign boundary cases.
    wave_display_idle = 1'b0;
    cycles(1);
    wave_display_idle = 1'b1;
    cycles(2);
    check_value("ridx_armed_pulse", 32'(read_index), 32'd1);
    send(16'h7FFF, 1'b0, 9'h000);
    send(16'h0001, 1'b0, 9'h000);
    send(16'h8000, 1'b0, 9'h000);
    send(16'h0000, 1'b1, 9'h000);

    // Second capture into half 0 with new_sample_ready held high; idle pulse mid-capture.
    @(posedge clk); #1;
    new_sample_ready = 1'b1;
    for (int i = 1; i < 256; i++) begin
      logic [15:0] s;
      s = 16'(i * 257);
      new_sample_in = s;
      exp_q.push_back({9'(i), to_ob(s)});
      @(posedge clk); #1;
      if (i == 100) wave_display_idle = 1'b0;
      if (i == 101) wave_display_idle = 1'b1;
    end
    new_sample_ready = 1'b0;
    cycles(2);
    check_value("state_wait2", 32'(dut.state_r), 32'(STATE_WAIT));
    check_value("ridx_active_pulse", 32'(read_index), 32'd1);

    // Strobe coinciding with idle edge in WAIT: flip, no write, sign recorded.
    wave_display_idle = 1'b0;
    cycles(2);
    wave_display_idle = 1'b1;
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'hFFFF;
    @(posedge clk); #1;
    new_sample_ready  = 1'b0;
    check_value("coinc_no_write", 32'(write_enable), 32'd0);
    @(posedge clk); #1;
    check_value("coinc_ridx", 32'(read_index), 32'd0);
    check_value("coinc_state", 32'(dut.state_r), 32'(STATE_ARMED));
    send(16'h7FFF, 1'b1, 9'h100);

    // Partial capture, then reset at count 0x40.
    for (int i = 1; i < 64; i++) send(16'(i * 64), 1'b1, 9'h100 + 9'(i));
    check_value("count_before_rst", 32'(dut.count_r), 32'h40);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_value("midrst_we", 32'(write_enable), 32'd0);
    check_value("midrst_addr", 32'(write_address), 32'd0);
    check_value("midrst_data", 32'(write_sample), 32'd0);
    check_value("midrst_ridx", 32'(read_index), 32'd0);
    check_value("midrst_state", 32'(dut.state_r), 32'(STATE_ARMED));
    @(negedge clk) reset = 1'b0;
    send(16'h0005, 1'b0, 9'h000);
    send(16'hFFFF, 1'b0, 9'h000);
    send(16'h0005, 1'b1, 9'h100);
    cycles(3);
    check_value("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
